// File: rtl/dfd_cla_debug_signals_ones_gen.sv
// Debug-signal stimulus generator for the CLA ones-count match logic.
// Drives a thermometer pattern of N ones and rotates it left one bit per
// step, holding each step for hold_cycles+1 clocks. The population count is
// invariant under rotation, so expected_ones_count is fixed for a sequence.
module dfd_cla_debug_signals_ones_gen #(
    parameter int DEBUG_SIGNALS_WIDTH = 64,
    parameter int CNT_W               = $clog2(DEBUG_SIGNALS_WIDTH) + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic [CNT_W-1:0]               ones_value,
    input  logic [15:0]                    hold_cycles,
    input  logic [15:0]                    num_steps,
    output logic [DEBUG_SIGNALS_WIDTH-1:0] debug_signals,
    output logic                           debug_signals_valid,
    output logic [CNT_W-1:0]               expected_ones_count,
    output logic                           busy,
    output logic                           done
);

    localparam int               W     = DEBUG_SIGNALS_WIDTH;
    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Requests above the bus width saturate to an all-ones pattern.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req);
        if (req > W_CNT) begin
            return W_CNT;
        end else begin
            return req;
        end
    endfunction

    // Bits [n-1:0] set, everything above cleared.
    function automatic logic [W-1:0] thermometer(input logic [CNT_W-1:0] n);
        logic [W-1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(n)) begin
                t[i] = 1'b1;
            end else begin
                t[i] = 1'b0;
            end
        end
        return t;
    endfunction

    // Pure rotate: the MSB wraps into bit 0, so popcount is preserved.
    function automatic logic [W-1:0] rotate_left(input logic [W-1:0] p);
        return {p[W-2:0], p[W-1]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [W-1:0]     pattern_r;
    logic [W-1:0]     pattern_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [15:0]      hold_cnt_r;
    logic [15:0]      hold_cnt_nxt_s;
    logic [15:0]      hold_cfg_r;
    logic [15:0]      hold_cfg_nxt_s;
    logic [15:0]      step_cnt_r;
    logic [15:0]      step_cnt_nxt_s;
    logic [15:0]      num_steps_r;
    logic [15:0]      num_steps_nxt_s;

    logic             accept_s;
    logic             hold_active_s;
    logic             last_step_s;

    // Shared decode of the sequencing conditions used by both comb processes.
    always_comb begin
        accept_s      = start && !stop;
        hold_active_s = (hold_cnt_r != 16'd0);
        last_step_s   = (num_steps_r != 16'd0) && (step_cnt_r == num_steps_r);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: stop always wins over start and over completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (hold_active_s) begin
                    state_nxt_s = ST_RUN;
                end else if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; all of them are registered below.
    always_comb begin
        pattern_nxt_s   = pattern_r;
        valid_nxt_s     = valid_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        count_nxt_s     = count_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        hold_cfg_nxt_s  = hold_cfg_r;
        step_cnt_nxt_s  = step_cnt_r;
        num_steps_nxt_s = num_steps_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    pattern_nxt_s   = thermometer(clamp_count(ones_value));
                    valid_nxt_s     = 1'b1;
                    busy_nxt_s      = 1'b1;
                    count_nxt_s     = clamp_count(ones_value);
                    hold_cnt_nxt_s  = hold_cycles;
                    hold_cfg_nxt_s  = hold_cycles;
                    step_cnt_nxt_s  = 16'd1;
                    num_steps_nxt_s = num_steps;
                end else begin
                    pattern_nxt_s = '0;
                    valid_nxt_s   = 1'b0;
                    busy_nxt_s    = 1'b0;
                    count_nxt_s   = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    pattern_nxt_s = '0;
                    valid_nxt_s   = 1'b0;
                    busy_nxt_s    = 1'b0;
                    count_nxt_s   = '0;
                end else if (hold_active_s) begin
                    hold_cnt_nxt_s = hold_cnt_r - 16'd1;
                end else if (last_step_s) begin
                    pattern_nxt_s = '0;
                    valid_nxt_s   = 1'b0;
                    busy_nxt_s    = 1'b0;
                    count_nxt_s   = '0;
                    done_nxt_s    = 1'b1;
                end else begin
                    pattern_nxt_s  = rotate_left(pattern_r);
                    hold_cnt_nxt_s = hold_cfg_r;
                    // Free-running sequences saturate rather than wrap the step count.
                    if (step_cnt_r != 16'hFFFF) begin
                        step_cnt_nxt_s = step_cnt_r + 16'd1;
                    end else begin
                        step_cnt_nxt_s = step_cnt_r;
                    end
                end
            end
            ST_DONE: begin
                pattern_nxt_s = '0;
                valid_nxt_s   = 1'b0;
                busy_nxt_s    = 1'b0;
                count_nxt_s   = '0;
            end
            default: begin
                pattern_nxt_s = '0;
                valid_nxt_s   = 1'b0;
                busy_nxt_s    = 1'b0;
                count_nxt_s   = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_r   <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            count_r     <= '0;
            hold_cnt_r  <= 16'd0;
            hold_cfg_r  <= 16'd0;
            step_cnt_r  <= 16'd0;
            num_steps_r <= 16'd0;
        end else begin
            pattern_r   <= pattern_nxt_s;
            valid_r     <= valid_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            count_r     <= count_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            hold_cfg_r  <= hold_cfg_nxt_s;
            step_cnt_r  <= step_cnt_nxt_s;
            num_steps_r <= num_steps_nxt_s;
        end
    end

    assign debug_signals       = pattern_r;
    assign debug_signals_valid = valid_r;
    assign expected_ones_count = count_r;
    assign busy                = busy_r;
    assign done                = done_r;

endmodule

// File: tb/tb_dfd_cla_debug_signals_ones_gen.sv
// Scoreboard bench for the ones-pattern generator at W=8.
module tb_dfd_cla_debug_signals_ones_gen;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W) + 1;

    logic             clock;
    logic             reset;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] ones_value;
    logic [15:0]      hold_cycles;
    logic [15:0]      num_steps;
    logic [W-1:0]     debug_signals;
    logic             debug_signals_valid;
    logic [CNT_W-1:0] expected_ones_count;
    logic             busy;
    logic             done;

    dfd_cla_debug_signals_ones_gen #(
        .DEBUG_SIGNALS_WIDTH(W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .stop               (stop),
        .ones_value         (ones_value),
        .hold_cycles        (hold_cycles),
        .num_steps          (num_steps),
        .debug_signals      (debug_signals),
        .debug_signals_valid(debug_signals_valid),
        .expected_ones_count(expected_ones_count),
        .busy               (busy),
        .done               (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         valid;
        logic [W-1:0] pat;
        int           cnt;
        logic         done;
        logic         contig;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_pop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Rotation by s of a block of n ones, computed positionally.
    function automatic logic [W-1:0] model_pat(input int n, input int s);
        logic [W-1:0] p;
        for (int i = 0; i < W; i++) begin
            int d;
            d = (((i - s) % W) + W) % W;
            p[i] = (d < n);
        end
        return p;
    endfunction

    function automatic int clamp_n(input int ones);
        return (ones > W) ? W : ones;
    endfunction

    task automatic push_pattern(input int n, input int s, input logic contig);
        exp_t e;
        e.valid  = 1'b1;
        e.pat    = model_pat(n, s);
        e.cnt    = n;
        e.done   = 1'b0;
        e.contig = contig;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int ones, input int hold, input int steps);
        exp_t e;
        int   n;
        n = clamp_n(ones);
        for (int s = 0; s < steps; s++) begin
            for (int h = 0; h <= hold; h++) begin
                push_pattern(n, s, !(s == 0 && h == 0));
            end
        end
        e.valid  = 1'b0;
        e.pat    = '0;
        e.cnt    = 0;
        e.done   = 1'b1;
        e.contig = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle the DUT presents valid or done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                if (debug_signals_valid || done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", {debug_signals_valid, done}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("valid", debug_signals_valid, e.valid);
                        check("pattern", debug_signals, e.pat);
                        check("ones_count", expected_ones_count, e.cnt);
                        check("done", done, e.done);
                        check("busy", busy, e.valid);
                        if (e.contig) begin
                            check("cycle_gap", cyc - last_pop, 64'd1);
                        end
                        last_pop = cyc;
                    end
                end else begin
                    check("idle_outputs_zero", {debug_signals, expected_ones_count, busy}, 64'd0);
                end
            end
        end
    end

    // Caller is at posedge+2; returns at posedge+2 with the block idle.
    task automatic run_seq(input int ones, input int hold, input int steps, input bit disturb);
        int budget;
        push_seq(ones, hold, steps);
        start       = 1'b1;
        stop        = 1'b0;
        ones_value  = CNT_W'(ones);
        hold_cycles = 16'(hold);
        num_steps   = 16'(steps);
        @(posedge clock);
        #1;
        check("first_latency_valid", debug_signals_valid, 64'd1);
        check("first_pattern", debug_signals, model_pat(clamp_n(ones), 0));
        #1;
        start = 1'b0;
        budget = (hold + 1) * steps + 20;
        while (exp_q.size() != 0 && budget > 0) begin
            if (disturb) begin
                ones_value  = CNT_W'($urandom);
                hold_cycles = 16'($urandom);
                num_steps   = 16'($urandom);
                start       = 1'($urandom);
            end
            @(posedge clock);
            #2;
            budget--;
        end
        start = 1'b0;
        check("seq_complete", exp_q.size(), 64'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        check("idle_after_done", {busy, debug_signals_valid, done}, 64'd0);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        ones_value  = '0;
        hold_cycles = 16'd0;
        num_steps   = 16'd0;
        #12;
        check("reset_outputs", {debug_signals, debug_signals_valid, expected_ones_count, busy, done}, 64'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset_idle", {debug_signals, debug_signals_valid, busy, done}, 64'd0);
        #1;

        // Basic, hold/wrap, clamp, zero.
        run_seq(3, 0, 3, 1'b0);
        run_seq(3, 1, 9, 1'b0);
        run_seq(12, 0, 2, 1'b0);
        run_seq(0, 0, 2, 1'b0);

        // start with stop in IDLE must not start.
        start = 1'b1;
        stop  = 1'b1;
        ones_value = CNT_W'(4);
        num_steps  = 16'd2;
        @(posedge clock);
        #1;
        check("start_stop_idle", {debug_signals_valid, busy}, 64'd0);
        #1;
        start = 1'b0;
        stop  = 1'b0;

        // Free-running walking one, then abort.
        for (int s = 0; s < 20; s++) begin
            push_pattern(1, s, s != 0);
        end
        start       = 1'b1;
        ones_value  = CNT_W'(1);
        hold_cycles = 16'd0;
        num_steps   = 16'd0;
        @(posedge clock);
        #1;
        check("free_first", debug_signals, 64'h01);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #2;
        stop = 1'b1;
        @(posedge clock);
        #1;
        check("stop_outputs", {debug_signals, debug_signals_valid, expected_ones_count, busy, done}, 64'd0);
        check("free_run_consumed", exp_q.size(), 64'd0);
        exp_q.delete();
        #1;
        stop = 1'b0;
        run_seq(3, 0, 3, 1'b0);

        // Randomized sequences with ignored start/config activity during RUN.
        for (int k = 0; k < 12; k++) begin
            run_seq($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(1, 12), 1'b1);
        end

        // Asynchronous reset mid-sequence.
        push_seq(5, 2, 10);
        start       = 1'b1;
        ones_value  = CNT_W'(5);
        hold_cycles = 16'd2;
        num_steps   = 16'd10;
        @(posedge clock);
        #2;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_outputs", {debug_signals, debug_signals_valid, expected_ones_count, busy, done}, 64'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #2;
        run_seq(3, 0, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
